// File: rtl/sync_fifo_pkg.sv
// Shared defaults and helpers for the single-clock FIFO.
package sync_fifo_pkg;
  localparam int DATA_WIDTH_D = 8;
  localparam int ADD_WIDTH_D  = 4;

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/sync_fifo_mem.sv
// Dual-port storage: synchronous write, registered read. Array is not reset;
// only the read register is, so r_data comes up as zero.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DW = DATA_WIDTH_D,
  parameter int AW = ADD_WIDTH_D
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  localparam int DEPTH = fifo_depth(AW);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: wrap-bit pointers, occupancy/almost flags, registered
// read port and sticky overflow/underflow flags.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int data_width   = DATA_WIDTH_D,
  parameter int add_width    = ADD_WIDTH_D,
  parameter int afull_level  = 14,
  parameter int aempty_level = 2
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  w_en,
  input  logic [data_width-1:0] w_data,
  input  logic                  r_en,
  input  logic                  err_clr,
  output logic [data_width-1:0] r_data,
  output logic                  r_valid,
  output logic                  wfull,
  output logic                  rempty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [add_width:0]    count,
  output logic                  overflow,
  output logic                  underflow
);
  logic [add_width:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic               rvalid_q, rvalid_d;
  logic               ovf_q, ovf_d, unf_q, unf_d;
  logic               wr_ok, rd_ok;

  // Equal pointers = empty; same address on opposite laps = full.
  assign rempty = (wptr_q == rptr_q);
  assign wfull  = (wptr_q[add_width] != rptr_q[add_width]) &&
                  (wptr_q[add_width-1:0] == rptr_q[add_width-1:0]);
  assign count  = wptr_q - rptr_q;

  assign almost_full  = int'(count) >= afull_level;
  assign almost_empty = int'(count) <= aempty_level;

  assign wr_ok = w_en && !wfull;
  assign rd_ok = r_en && !rempty;

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    rvalid_d = rd_ok;
    if (wr_ok) wptr_d = wptr_q + 1'b1;
    if (rd_ok) rptr_d = rptr_q + 1'b1;
    // A new error in the clearing cycle keeps the flag set.
    ovf_d = (w_en && wfull)  || (ovf_q && !err_clr);
    unf_d = (r_en && rempty) || (unf_q && !err_clr);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  sync_fifo_mem #(.DW(data_width), .AW(add_width)) u_mem (
    .clk   (wclk),
    .rst_n (wrst_n),
    .we    (wr_ok),
    .waddr (wptr_q[add_width-1:0]),
    .wdata (w_data),
    .re    (rd_ok),
    .raddr (rptr_q[add_width-1:0]),
    .rdata (r_data)
  );

  assign r_valid   = rvalid_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: queue-based reference model feeds expected
// status/data queues; a monitor compares after every clock edge.
module tb_sync_fifo;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int AFL = 14;
  localparam int AEL = 2;

  typedef struct {
    int           cnt;
    bit           rv;
    bit           ov;
    bit           un;
    logic [DW-1:0] rd;
  } st_t;

  logic          wclk = 1'b0;
  logic          wrst_n = 1'b1;
  logic          w_en = 1'b0, r_en = 1'b0, err_clr = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic [DW-1:0] r_data;
  logic          r_valid, wfull, rempty, almost_full, almost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;

  int nchk = 0;
  int nerr = 0;

  logic [DW-1:0] mq[$];   // model contents
  logic [DW-1:0] exq[$];  // expected popped words
  st_t           stq[$];  // expected post-edge status
  bit            m_ov = 0, m_un = 0;
  logic [DW-1:0] m_rd = '0;

  sync_fifo #(.data_width(DW), .add_width(AW), .afull_level(AFL), .aempty_level(AEL)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .w_en(w_en), .w_data(w_data), .r_en(r_en),
    .err_clr(err_clr), .r_data(r_data), .r_valid(r_valid), .wfull(wfull),
    .rempty(rempty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model decides acceptance from pre-edge occupancy.
  task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    bit  full, empty, rv;
    st_t s;
    @(negedge wclk);
    w_en = w; w_data = d; r_en = r; err_clr = c;
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    rv = 0;
    m_ov = (w && full)  || (m_ov && !c);
    m_un = (r && empty) || (m_un && !c);
    if (r && !empty) begin
      m_rd = mq.pop_front();
      exq.push_back(m_rd);
      rv = 1;
    end
    if (w && !full) mq.push_back(d);
    s.cnt = mq.size(); s.rv = rv; s.ov = m_ov; s.un = m_un; s.rd = m_rd;
    stq.push_back(s);
  endtask

  task automatic model_reset();
    mq.delete(); exq.delete(); stq.delete();
    m_ov = 0; m_un = 0; m_rd = '0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_rempty"}, rempty, 1);
    chk({tag, "_wfull"}, wfull, 0);
    chk({tag, "_aempty"}, almost_empty, 1);
    chk({tag, "_afull"}, almost_full, 0);
    chk({tag, "_r_data"}, r_data, 0);
    chk({tag, "_r_valid"}, r_valid, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_unf"}, underflow, 0);
  endtask

  // Monitor: compares status every checked edge, pops the data scoreboard on r_valid.
  always @(posedge wclk) begin
    st_t s;
    #1;
    if (stq.size() != 0) begin
      s = stq.pop_front();
      chk("count", count, s.cnt);
      chk("wfull", wfull, s.cnt == DEPTH);
      chk("rempty", rempty, s.cnt == 0);
      chk("almost_full", almost_full, s.cnt >= AFL);
      chk("almost_empty", almost_empty, s.cnt <= AEL);
      chk("overflow", overflow, s.ov);
      chk("underflow", underflow, s.un);
      chk("r_valid", r_valid, s.rv);
      if (r_valid) begin
        if (exq.size() == 0) chk("r_valid_no_data", r_valid, 0);
        else                 chk("r_data", r_data, exq.pop_front());
      end else begin
        chk("r_data_hold", r_data, s.rd);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Power-on reset
    #2 wrst_n = 1'b0;
    #1 chk_reset_vals("por");
    @(negedge wclk); wrst_n = 1'b1;

    // Fill and drain
    for (int i = 0; i < DEPTH; i++) cycle(1, 8'(i), 0, 0);
    for (int i = 0; i < DEPTH; i++) cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 0, 0);

    // Overflow while full, then clear; 0xAA must never come out
    for (int i = 0; i < DEPTH; i++) cycle(1, 8'(8'h40 + i), 0, 0);
    cycle(1, 8'hAA, 0, 0);
    cycle(0, 8'h00, 0, 1);
    for (int i = 0; i < DEPTH; i++) cycle(0, 8'h00, 1, 0);

    // Underflow while empty, then clear
    cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 0, 0);
    cycle(0, 8'h00, 0, 1);

    // Simultaneous at count 8
    for (int i = 0; i < 8; i++) cycle(1, 8'(8'h80 + i), 0, 0);
    for (int i = 0; i < 20; i++) cycle(1, 8'($urandom), 1, 0);
    for (int i = 0; i < 8; i++) cycle(0, 8'h00, 1, 0);

    // Simultaneous when empty: write only, underflow
    cycle(1, 8'h5C, 1, 0);
    cycle(0, 8'h00, 0, 1);
    cycle(0, 8'h00, 1, 0);

    // Simultaneous when full: read only, overflow; err_clr collides with new error
    for (int i = 0; i < DEPTH; i++) cycle(1, 8'(8'hC0 + i), 0, 0);
    cycle(1, 8'hEE, 1, 0);
    cycle(1, 8'hEF, 0, 0);
    cycle(1, 8'hF0, 0, 1);
    cycle(0, 8'h00, 0, 1);
    for (int i = 0; i < DEPTH; i++) cycle(0, 8'h00, 1, 0);

    // Wrap-around with write/read pairs
    for (int i = 0; i < 40; i++) begin
      cycle(1, 8'($urandom), 0, 0);
      cycle(0, 8'h00, 1, 0);
    end

    // Random traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50,
            $urandom_range(0, 19) == 0);
    for (int i = 0; i < DEPTH + 1; i++) cycle(0, 8'h00, 1, 1);

    // Mid-stream asynchronous reset with 5 words stored and r_valid high
    for (int i = 0; i < 6; i++) cycle(1, 8'(8'h11 + i), 0, 0);
    cycle(0, 8'h00, 1, 0);
    @(posedge wclk);
    #3;
    w_en = 0; r_en = 0; err_clr = 0;
    wrst_n = 1'b0;
    #1 chk_reset_vals("async");
    model_reset();
    @(negedge wclk); wrst_n = 1'b1;
    #1 chk("post_rst_count", count, 0);
    chk("post_rst_rempty", rempty, 1);
    cycle(1, 8'h3D, 0, 0);
    cycle(1, 8'h3E, 0, 0);
    cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 0, 0);
    cycle(0, 8'h00, 0, 0);

    @(negedge wclk);
    chk("scoreboard_leftover", exq.size(), 0);
    chk("status_leftover", stq.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
